axi4_cmd_master: RTL

AXI4-Lite-style single-outstanding initiator. It drives the address/data/response channels of axi4_slave from a simple command/response interface. A local request (read or write) becomes one AXI transaction, and the result is returned on a held response port. A timeout counter aborts transactions when the slave never answers.

---
 rtl/axi4_cmd_master.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_cmd_master.sv
// Purpose: single-outstanding AXI4-Lite initiator; turns one local read/write command into one AXI transaction.
// Latency: accept at N, AW/W/AR handshake N+1, B/R at N+2, rsp_valid sampled at N+3 with a zero-wait slave.
// Backpressure: req_ready only in IDLE; response held on rsp_* until rsp_ready; bus states abort after TIMEOUT cycles.
//
// Ports:
//   clk, reset                      : clock and synchronous active-high reset
//   req_* (valid/ready/write/addr/wdata/wstrb) : local command interface
//   rsp_* (valid/ready/write/rdata/resp/timeout) : local response interface, payload held while rsp_valid
//   aw*/w*/b*/ar*/r*                : AXI4-Lite master channels toward the slave
module axi4_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    // The counter holds the number of bus cycles already spent; the cycle in
    // which it reads TIMEOUT-1 is the TIMEOUT-th bus cycle and the last one allowed.
    localparam int               TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST   = TO_LAST_I[CNT_W-1:0];

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                bus_state;
    logic                expired;
    logic                do_abort;

    logic                req_ready_nxt;
    logic                rsp_valid_nxt, rsp_write_nxt, rsp_timeout_nxt;
    logic [DATA_W-1:0]   rsp_rdata_nxt;
    logic [1:0]          rsp_resp_nxt;
    logic [ADDR_W-1:0]   awaddr_nxt, araddr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic [DATA_W/8-1:0] wstrb_nxt;
    logic                awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;

    assign bus_state = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                       (state == S_RD_REQ) || (state == S_RD_DATA);
    // Once the budget is spent it stays spent (counter saturates), so a
    // transaction that squeaked through one phase cannot linger in the next.
    assign expired   = (TIMEOUT != 0) && (cnt >= TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
            awaddr      <= '0;
            awvalid     <= 1'b0;
            wdata       <= '0;
            wstrb       <= '0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            araddr      <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            req_ready   <= req_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_write   <= rsp_write_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_resp    <= rsp_resp_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            awaddr      <= awaddr_nxt;
            awvalid     <= awvalid_nxt;
            wdata       <= wdata_nxt;
            wstrb       <= wstrb_nxt;
            wvalid      <= wvalid_nxt;
            bready      <= bready_nxt;
            araddr      <= araddr_nxt;
            arvalid     <= arvalid_nxt;
            rready      <= rready_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        req_ready_nxt   = req_ready;
        rsp_valid_nxt   = rsp_valid;
        rsp_write_nxt   = rsp_write;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_resp_nxt    = rsp_resp;
        rsp_timeout_nxt = rsp_timeout;
        awaddr_nxt      = awaddr;
        awvalid_nxt     = awvalid;
        wdata_nxt       = wdata;
        wstrb_nxt       = wstrb;
        wvalid_nxt      = wvalid;
        bready_nxt      = bready;
        araddr_nxt      = araddr;
        arvalid_nxt     = arvalid;
        rready_nxt      = rready;
        do_abort        = 1'b0;

        if (bus_state && (cnt != '1)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    req_ready_nxt = 1'b0;
                    cnt_nxt       = '0;
                    if (req_write) begin
                        awaddr_nxt  = req_addr;
                        wdata_nxt   = req_wdata;
                        wstrb_nxt   = req_wstrb;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = S_WR_REQ;
                    end else begin
                        araddr_nxt  = req_addr;
                        arvalid_nxt = 1'b1;
                        state_nxt   = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                if (awvalid && awready) awvalid_nxt = 1'b0;
                if (wvalid && wready)   wvalid_nxt  = 1'b0;
                // A channel counts as done if it already dropped valid or is handshaking now.
                if ((!awvalid || awready) && (!wvalid || wready)) begin
                    bready_nxt = 1'b1;
                    state_nxt  = S_WR_RESP;
                end else if (expired) begin
                    do_abort = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (bvalid && bready) begin
                    bready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_write_nxt   = 1'b1;
                    rsp_rdata_nxt   = '0;
                    rsp_resp_nxt    = bresp;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = S_RESP;
                end else if (expired) begin
                    do_abort = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (arvalid && arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = S_RD_DATA;
                end else if (expired) begin
                    do_abort = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (rvalid && rready) begin
                    rready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_write_nxt   = 1'b0;
                    rsp_rdata_nxt   = rdata;
                    rsp_resp_nxt    = rresp;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = S_RESP;
                end else if (expired) begin
                    do_abort = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_nxt   = 1'b0;
                    rsp_timeout_nxt = 1'b0;
                    req_ready_nxt   = 1'b1;
                    state_nxt       = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort releases every AXI valid/ready and reports a synthetic DECERR-coded timeout.
        if (do_abort) begin
            awvalid_nxt     = 1'b0;
            wvalid_nxt      = 1'b0;
            bready_nxt      = 1'b0;
            arvalid_nxt     = 1'b0;
            rready_nxt      = 1'b0;
            rsp_valid_nxt   = 1'b1;
            rsp_write_nxt   = (state == S_WR_REQ) || (state == S_WR_RESP);
            rsp_rdata_nxt   = '0;
            rsp_resp_nxt    = 2'b11;
            rsp_timeout_nxt = 1'b1;
            state_nxt       = S_RESP;
        end
    end

endmodule
